// File: rtl/vape_er_cfg_ctrl.sv
// Execution-region config controller: programs ER bounds, locks them while armed/running, tracks a run.
// Optional exec-cycle counter is built when VAPE_EXEC_CNT_EN is defined.
module vape_er_cfg_ctrl #(
    parameter logic [15:0] CFG_MIN_ADDR = 16'h0140,
    parameter logic [15:0] CFG_MAX_ADDR = 16'h0142,
    parameter logic [15:0] CFG_CTL_ADDR = 16'h0144
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pc,
    input  logic        exec_in,
    input  logic        cpu_wr,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    input  logic        dma_wr,
    input  logic [15:0] dma_addr,
    input  logic [15:0] dma_wdata,
    output logic [15:0] er_min,
    output logic [15:0] er_max,
    output logic        cfg_locked,
    output logic        run_done,
    output logic        dma_drop,
`ifdef VAPE_EXEC_CNT_EN
    output logic [15:0] exec_cycles,
`endif
    output logic        viol
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0] state;
    logic [1:0] state_n;

    // Write strobes are single-cycle requests with no backpressure: a write is
    // either taken on the edge where wr is high or discarded, never retried.
    logic cpu_bound, dma_bound, cpu_hit, dma_hit;
    assign cpu_bound = cpu_wr && (cpu_addr == CFG_MIN_ADDR || cpu_addr == CFG_MAX_ADDR);
    assign dma_bound = dma_wr && (dma_addr == CFG_MIN_ADDR || dma_addr == CFG_MAX_ADDR);
    assign cpu_hit   = cpu_bound || (cpu_wr && cpu_addr == CFG_CTL_ADDR);
    assign dma_hit   = dma_bound || (dma_wr && dma_addr == CFG_CTL_ADDR);

    logic        sel_valid;
    logic [15:0] sel_addr;
    logic [15:0] sel_wdata;
    assign sel_valid = cpu_hit || dma_hit;
    assign sel_addr  = cpu_hit ? cpu_addr  : dma_addr;
    assign sel_wdata = cpu_hit ? cpu_wdata : dma_wdata;

    logic ctl_wr, arm_req, clr_req;
    assign ctl_wr  = sel_valid && (sel_addr == CFG_CTL_ADDR);
    assign arm_req = ctl_wr && sel_wdata[0];
    assign clr_req = ctl_wr && sel_wdata[1];

    logic        in_idle;
    logic        min_we, max_we;
    logic        bounds_ok;
    logic        viol_set, viol_clr;
    logic        done_pulse;
    logic        start_run;
    assign in_idle   = (state == ST_IDLE);
    assign bounds_ok = (er_min < er_max);
    assign min_we    = in_idle && sel_valid && (sel_addr == CFG_MIN_ADDR);
    assign max_we    = in_idle && sel_valid && (sel_addr == CFG_MAX_ADDR);

    always_comb begin
        state_n    = state;
        viol_set   = 1'b0;
        viol_clr   = 1'b0;
        done_pulse = 1'b0;
        start_run  = 1'b0;
        case (state)
            ST_IDLE: begin
                // ARM compares the bounds as registered before this edge.
                if (arm_req) begin
                    if (bounds_ok) state_n = ST_ARMED;
                    else           viol_set = 1'b1;
                end
            end
            ST_ARMED: begin
                if (clr_req) begin
                    state_n = ST_IDLE;
                end else if (exec_in && pc == er_min) begin
                    state_n   = ST_RUN;
                    start_run = 1'b1;
                end
            end
            ST_RUN: begin
                if (clr_req) viol_set = 1'b1;
                // Losing exec always wins over reaching the end address.
                if (!exec_in) begin
                    state_n = ST_ARMED;
                end else if (pc == er_max) begin
                    state_n    = ST_DONE;
                    done_pulse = 1'b1;
                end
            end
            ST_DONE: begin
                if (clr_req) begin
                    state_n  = ST_IDLE;
                    viol_clr = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        if (!in_idle && (cpu_bound || dma_bound)) viol_set = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            er_min     <= 16'h0000;
            er_max     <= 16'h0000;
            cfg_locked <= 1'b0;
            run_done   <= 1'b0;
            dma_drop   <= 1'b0;
            viol       <= 1'b0;
        end else begin
            state      <= state_n;
            cfg_locked <= (state_n != ST_IDLE);
            run_done   <= done_pulse;
            dma_drop   <= in_idle && cpu_hit && dma_hit;
            if (min_we) er_min <= sel_wdata;
            if (max_we) er_max <= sel_wdata;
            if (viol_clr)      viol <= 1'b0;
            else if (viol_set) viol <= 1'b1;
        end
    end

`ifdef VAPE_EXEC_CNT_EN
    // Counts every cycle spent in RUN, including the cycle that completes or aborts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exec_cycles <= 16'h0000;
        end else if (start_run) begin
            exec_cycles <= 16'h0000;
        end else if (state == ST_RUN && exec_cycles != 16'hFFFF) begin
            exec_cycles <= exec_cycles + 16'd1;
        end
    end
`endif

endmodule
